// File: rtl/rr_grant_arbiter_if.sv
// rtl/rr_grant_arbiter_if.sv - request/grant signal bundle for rr_grant_arbiter
interface rr_grant_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   REQ;
  logic [N-1:0]   GNT;
  logic [IDW-1:0] GNT_ID;
  logic           BUSY;
  logic           TIMEOUT;

  // Requester side drives REQ and observes the grant
  modport master (output REQ, input GNT, GNT_ID, BUSY, TIMEOUT);
  // Arbiter side observes REQ and drives the grant
  modport slave  (input REQ, output GNT, GNT_ID, BUSY, TIMEOUT);
endinterface

// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - round-robin hold-until-release arbiter with max-hold timeout
module rr_grant_arbiter #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic              CLK,
  input  logic              R,
  rr_grant_arbiter_if.slave bus
);

  localparam int             CW       = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0]  HOLD_LIM = CW'(MAX_HOLD);
  localparam logic [N-1:0]   ONE_HOT0 = N'(1);
  localparam logic [IDW-1:0] PTR_RST  = IDW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RECOVER
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout;

  logic           win_valid;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] idx;
  logic           owner_req;
  logic           take;
  logic           expire;
  logic           drop;

  assign owner_req = bus.REQ[gnt_id];

  // Pick the first requester above ptr, wrapping so ptr itself is checked last
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IDW'((int'(ptr) + i) % N);
      if (!win_valid && bus.REQ[idx]) begin
        win_valid = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Decide this edge's action: new grant, timeout revoke, drop to idle, or hold
  always_comb begin
    take   = 1'b0;
    expire = 1'b0;
    drop   = 1'b0;
    case (state)
      S_GRANT: begin
        if (owner_req) begin
          expire = (MAX_HOLD != 0) && (cnt == HOLD_LIM);
        end else if (win_valid) begin
          take = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
      default: begin
        if (win_valid) begin
          take = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    endcase
  end

  // Arbiter state and registered outputs; reset clears everything immediately
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state   <= S_IDLE;
      ptr     <= PTR_RST;
      cnt     <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= expire;
      if (take) begin
        state  <= S_GRANT;
        gnt    <= ONE_HOT0 << win_id;
        gnt_id <= win_id;
        ptr    <= win_id;
        cnt    <= CW'(1);
        busy   <= 1'b1;
      end else if (expire) begin
        state <= S_RECOVER;
        gnt   <= '0;
        busy  <= 1'b0;
      end else if (drop) begin
        state <= S_IDLE;
        gnt   <= '0;
        busy  <= 1'b0;
      end else if ((MAX_HOLD != 0) && (cnt < HOLD_LIM)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.GNT     = gnt;
  assign bus.GNT_ID  = gnt_id;
  assign bus.BUSY    = busy;
  assign bus.TIMEOUT = timeout;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - randomized and directed bench for rr_grant_arbiter
module tb_rr_grant_arbiter;

  logic       CLK;
  logic       R;
  logic [3:0] req;
  bit         run_cmp;
  int         n_cmp;
  int         n_err;

  rr_grant_arbiter_if #(.N(4), .IDW(2)) bus8 ();
  rr_grant_arbiter_if #(.N(4), .IDW(2)) bus0 ();

  assign bus8.REQ = req;
  assign bus0.REQ = req;

  rr_grant_arbiter #(.N(4), .IDW(2), .MAX_HOLD(8)) dut8 (.CLK(CLK), .R(R), .bus(bus8));
  rr_grant_arbiter #(.N(4), .IDW(2), .MAX_HOLD(0)) dut0 (.CLK(CLK), .R(R), .bus(bus0));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [3:0] o_gnt [2];
  logic [1:0] o_id  [2];
  logic       o_busy[2];
  logic       o_to  [2];
  assign o_gnt[0] = bus8.GNT;  assign o_gnt[1] = bus0.GNT;
  assign o_id[0]  = bus8.GNT_ID; assign o_id[1] = bus0.GNT_ID;
  assign o_busy[0] = bus8.BUSY; assign o_busy[1] = bus0.BUSY;
  assign o_to[0]  = bus8.TIMEOUT; assign o_to[1] = bus0.TIMEOUT;

  // Behavioural model: who owns the resource, for how long, and who was served last
  int m_mh   [2] = '{8, 0};
  int m_owner[2] = '{-1, -1};
  int m_held [2] = '{0, 0};
  int m_ptr  [2] = '{3, 3};
  int m_last [2] = '{0, 0};
  bit m_to   [2] = '{1'b0, 1'b0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input int k, input logic [3:0] r);
    int idx;
    for (int off = 1; off <= 4; off++) begin
      idx = (m_ptr[k] + off) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_held[k]  = 0;
      m_ptr[k]   = 3;
      m_last[k]  = 0;
      m_to[k]    = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic [3:0] r);
    int w;
    m_to[k] = 1'b0;
    w = pick(k, r);
    if (m_owner[k] >= 0 && r[m_owner[k]]) begin
      if (m_mh[k] != 0 && m_held[k] >= m_mh[k]) begin
        m_owner[k] = -1;
        m_to[k]    = 1'b1;
      end else begin
        m_held[k]++;
      end
    end else if (w >= 0) begin
      m_owner[k] = w;
      m_last[k]  = w;
      m_ptr[k]   = w;
      m_held[k]  = 1;
    end else begin
      m_owner[k] = -1;
    end
  endtask

  // Advance the model on the same events the DUT sees
  always @(posedge CLK or negedge R) begin
    if (!R) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k, req);
  end

  // Compare both instances against the model every cycle
  always @(negedge CLK) begin
    if (run_cmp) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("gnt[%0d]", k), 32'(o_gnt[k]),
            (m_owner[k] >= 0) ? (32'd1 << m_owner[k]) : 32'd0);
        chk($sformatf("gnt_id[%0d]", k), 32'(o_id[k]), 32'(m_last[k]));
        chk($sformatf("busy[%0d]", k), 32'(o_busy[k]), 32'(m_owner[k] >= 0));
        chk($sformatf("timeout[%0d]", k), 32'(o_to[k]), 32'(m_to[k]));
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    R = 1'b1;
    req = 4'b0000;
    #1 R = 1'b0;
    req = 4'b1111;
    run_cmp = 1'b1;

    // Reset state with all requests high
    tick();
    chk("rst_gnt", 32'(bus8.GNT), 32'h0);
    chk("rst_busy", 32'(bus8.BUSY), 32'h0);
    chk("rst_to", 32'(bus8.TIMEOUT), 32'h0);
    R = 1'b1;
    tick();
    chk("first_gnt", 32'(bus8.GNT), 32'b0001);
    chk("first_id", 32'(bus8.GNT_ID), 32'd0);
    req = 4'b0000;
    tick();

    // Back-to-back handoff without a dead cycle
    req = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("b2b_hold", 32'(bus0.GNT), 32'b0010);
    end
    req = 4'b1000;
    tick();
    chk("b2b_next", 32'(bus0.GNT), 32'b1000);
    req = 4'b0010;
    tick();
    chk("b2b_back", 32'(bus0.GNT), 32'b0010);
    req = 4'b0000;
    tick();
    chk("b2b_idle", 32'(bus0.BUSY), 32'h0);

    // Idle return keeps the last owner id
    req = 4'b0100;
    tick();
    chk("idle_g1", 32'(bus8.GNT), 32'b0100);
    tick();
    chk("idle_g2", 32'(bus8.GNT), 32'b0100);
    req = 4'b0000;
    tick();
    chk("idle_gnt", 32'(bus8.GNT), 32'h0);
    chk("idle_busy", 32'(bus8.BUSY), 32'h0);
    chk("idle_id", 32'(bus8.GNT_ID), 32'd2);
    req = 4'b0111;
    tick();
    chk("idle_scan", 32'(bus8.GNT), 32'b0001);
    req = 4'b0000;
    tick();

    // Asynchronous reset between edges
    req = 4'b0010;
    tick();
    chk("ar_pre", 32'(bus8.GNT), 32'b0010);
    #2 R = 1'b0;
    #1;
    chk("ar_gnt", 32'(bus8.GNT), 32'h0);
    chk("ar_busy", 32'(bus8.BUSY), 32'h0);
    chk("ar_to", 32'(bus8.TIMEOUT), 32'h0);
    chk("ar_gnt0", 32'(bus0.GNT), 32'h0);
    @(negedge CLK);
    R = 1'b1;
    req = 4'b1111;
    tick();
    chk("ar_after", 32'(bus8.GNT), 32'b0001);

    // Fairness: each owner drops for a cycle after being granted
    for (int j = 1; j <= 4; j++) begin
      req = 4'b1111 & ~(4'b0001 << ((j - 1) % 4));
      tick();
      chk("fair", 32'(bus8.GNT), 32'b0001 << (j % 4));
    end
    req = 4'b0000;
    tick();

    // Timeout: position ptr at 3 so requester 0 goes first
    req = 4'b1000;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0101;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("to_g0", 32'(bus8.GNT), 32'b0001);
    end
    tick();
    chk("to_rec_gnt", 32'(bus8.GNT), 32'h0);
    chk("to_pulse", 32'(bus8.TIMEOUT), 32'h1);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("to_g2", 32'(bus8.GNT), 32'b0100);
    end
    req = 4'b0001;
    for (int rep = 0; rep < 2; rep++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        chk("solo_g", 32'(bus8.GNT), 32'b0001);
        chk("solo_to", 32'(bus8.TIMEOUT), 32'h0);
      end
      tick();
      chk("solo_rec", 32'(bus8.GNT), 32'h0);
      chk("solo_pulse", 32'(bus8.TIMEOUT), 32'h1);
    end
    req = 4'b0000;
    tick();

    // Randomized traffic with persistent requests and occasional mid-cycle reset
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 R = 1'b0;
        #1;
        chk("rnd_ar_gnt", 32'(bus8.GNT), 32'h0);
        chk("rnd_ar_busy", 32'(bus0.BUSY), 32'h0);
        @(negedge CLK);
        R = 1'b1;
      end
    end

    @(negedge CLK);
    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
Round-robin arbiter that shares one downstream resource among N requesters. Typical targets are a shared bus segment or the output of the OR-combined request/valid tree. It issues a registered one-hot grant with hold-until-release semantics, plus an optional maximum-hold timeout that forces rotation. It is built for synthesis onto the OSU tsmc018 cell library in the SoC flow, and all state elements map to DFFSR-style flops.

Parameters:
N, 4, number of requesters (2..16).
IDW, 2, width of GNT_ID; must equal ceil(log2(N)).
MAX_HOLD, 8, maximum consecutive grant cycles per owner; 0 disables the timeout.

Ports:
CLK  input  1  single clock; all state updates on the rising edge.
R  input  1  asynchronous active-low reset.
REQ  input  N  request vector; bit i is held high by requester i until it is done.
GNT  output  N  registered one-hot grant; all-zero when no grant is active.
GNT_ID  output  IDW  binary index of the current or last owner.
BUSY  output  1  OR-reduction of GNT, registered.
TIMEOUT  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (R=0, asynchronous):
  - GNT=0, GNT_ID=0, BUSY=0, TIMEOUT=0.
  - State is IDLE, hold counter is 0, and the priority pointer PTR is N-1, so requester 0 has first priority.
- Release of R is synchronous to CLK; the first evaluation happens at the first rising edge with R=1.
- States: IDLE, GRANT, RECOVER.
- Arbitration function: scan REQ starting at index PTR+1 mod N upward with wrap-around; the first set bit wins. Over a scan, PTR itself is checked last.
- IDLE:
  - At an edge with REQ!=0: GNT=onehot(winner), GNT_ID=winner, PTR=winner, hold counter=1, go to GRANT.
  - Grant latency is 1 cycle from REQ being sampled high.
  - If REQ=0, remain in IDLE with GNT=0.
- GRANT (owner = GNT_ID):
  - REQ[owner]=1 and (MAX_HOLD=0 or counter<MAX_HOLD): hold the grant and increment the counter, saturating at MAX_HOLD.
  - REQ[owner]=0 and some other REQ bit set: at the same edge, grant the next winner with no dead cycle. Set PTR=winner, counter=1, stay in GRANT.
  - REQ[owner]=0 and REQ=0: GNT=0, go to IDLE; GNT_ID keeps the last owner.
  - MAX_HOLD!=0, counter==MAX_HOLD and REQ[owner]=1: GNT=0, TIMEOUT=1 for one cycle, go to RECOVER. The owner's grant lasted exactly MAX_HOLD cycles.
- RECOVER:
  - Lasts exactly one cycle with GNT=0.
  - At the next edge, arbitrate from PTR+1. If REQ!=0, go to GRANT; otherwise go to IDLE.
  - The timed-out owner wins again only if it is the sole requester.
- REQ bits of non-owners never affect the current grant. Only the owner's release or the timeout ends it.
- GNT is always one-hot or zero, and BUSY==|GNT every cycle.
- Reset asserted mid-grant: outputs clear immediately, without waiting for CLK.
- Any MAX_HOLD=1 configuration is legal: each grant lasts one cycle, then one RECOVER cycle follows.

Test Plan:
1. Reset state: hold R=0 while REQ=4'b1111 -> GNT=0, BUSY=0, TIMEOUT=0. Release R -> first edge gives GNT=4'b0001, GNT_ID=0.
2. Back-to-back rotation: REQ=4'b1010 held, MAX_HOLD=0, owner drops after 3 cycles.
   - GNT=0010 for 3 cycles, then 1000 at the edge where REQ[1]=0 is sampled, with no zero cycle between.
   - When bit 3 drops, GNT returns to 0010 only if REQ[1] is re-raised; otherwise GNT=0.
3. Fairness: REQ=4'b1111, each owner drops its request for one cycle after being granted. Grant order is 0,1,2,3,0, and no requester is granted twice before all others are served.
4. Timeout: MAX_HOLD=8, REQ=4'b0101 held constant.
   - GNT=0001 for exactly 8 cycles, then GNT=0 with TIMEOUT=1 for 1 cycle, then GNT=0100 for 8 cycles.
   - With REQ=0001 only, the sequence 8 granted, 1 recover, 8 granted repeats.
5. Idle return: single REQ=0100 pulse held 2 cycles -> GNT=0100 for 2 cycles, then GNT=0, BUSY=0, GNT_ID stays 2. The next REQ=0111 grants requester 0 first (scan starts at 3).
6. Asynchronous reset mid-grant: assert R=0 between clock edges while GNT=0010 -> GNT, BUSY and TIMEOUT clear before the next edge, and PTR resets so requester 0 wins first afterwards.
